// File: rtl/group_arb_pkg.sv
// group_arb_pkg: shared FSM states, error data and index type for group_req_arbiter
package group_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;
  localparam int ARB_N_REQ = 4;
  typedef logic [$clog2(ARB_N_REQ)-1:0] idx_t;
endpackage

// File: rtl/group_req_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first active requester at or after ptr
module rr_arbiter import group_arb_pkg::*; #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx
);
  localparam int IW = $clog2(N_REQ);
  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N_REQ]) idx = IW'((int'(ptr) + i) % N_REQ);
    grant = (req == '0) ? '0 : (N_REQ'(1) << idx);
  end
endmodule

// File: rtl/group_req_arbiter.sv
// group_req_arbiter: round-robin sharing of one group static port; watchdog under GROUP_ARB_TIMEOUT_EN
module group_req_arbiter import group_arb_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_wen,
  input  logic [N_REQ-1:0]          req_ren,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      req_err,
  output logic                      static_wen,
  output logic                      static_ren,
  output logic [ADDR_W-1:0]         static_addr,
  output logic [DATA_W-1:0]         static_wdata,
  input  logic [DATA_W-1:0]         static_rdata,
  input  logic                      static_ready,
  output logic                      scan_id,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy
);
  localparam int IW = $clog2(N_REQ);
  state_t state;
  logic [IW-1:0] ptr, idx;
  logic [N_REQ-1:0] grant;
  logic wr_q, rd_q, err_q, timeout;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req(req_wen | req_ren),
    .ptr(ptr),
    .grant(grant),
    .idx(idx)
  );
`ifdef GROUP_ARB_TIMEOUT_EN
  logic [$clog2(TIMEOUT+1)-1:0] wdog;
  always_ff @(posedge clk) wdog <= (rst || state != BUSY) ? '0 : wdog + 1'b1;
  assign timeout = (state == BUSY) && (wdog == $bits(wdog)'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT > 0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: if (|grant) begin
          state    <= BUSY;
          grant_id <= idx;
          wr_q     <= req_wen[idx];
          rd_q     <= !req_wen[idx];
          addr_q   <= req_addr[idx*ADDR_W +: ADDR_W];
          wdata_q  <= req_wdata[idx*DATA_W +: DATA_W];
        end
        BUSY: if (static_ready) begin
          state   <= DONE;
          rdata_q <= wr_q ? '0 : static_rdata;
          err_q   <= 1'b0;
        end else if (timeout) begin
          state   <= DONE;
          rdata_q <= DATA_W'(ARB_ERR_DATA);
          err_q   <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          ptr   <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign busy         = state != IDLE;
  assign scan_id      = state == BUSY;
  assign static_wen   = scan_id && wr_q;
  assign static_ren   = scan_id && rd_q;
  assign static_addr  = addr_q;
  assign static_wdata = wdata_q;
  assign req_ready    = (state == DONE) ? (N_REQ'(1) << grant_id) : '0;
  assign req_rdata    = (state == DONE) ? rdata_q : '0;
  assign req_err      = (state == DONE) && err_q;
endmodule

// File: tb/tb_group_req_arbiter.sv
// tb_group_req_arbiter: vector table plus hand sequences; grants and completions scoreboarded
module tb_group_req_arbiter;
  logic clk = 0, rst = 1;
  logic [3:0] req_wen = 0, req_ren = 0, req_ready;
  logic [79:0] req_addr = 0;
  logic [127:0] req_wdata = 0;
  logic [31:0] req_rdata, static_wdata, static_rdata = 0;
  logic req_err, static_wen, static_ren, scan_id, busy;
  logic [19:0] static_addr;
  logic [1:0] grant_id;
  logic resp_rdy = 0, idle_pulse = 0, static_ready;
  assign static_ready = resp_rdy | idle_pulse;
  always #5 clk = ~clk;

  group_req_arbiter #(.N_REQ(4), .ADDR_W(20), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_wen(req_wen), .req_ren(req_ren), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .req_rdata(req_rdata), .req_err(req_err),
    .static_wen(static_wen), .static_ren(static_ren), .static_addr(static_addr),
    .static_wdata(static_wdata), .static_rdata(static_rdata), .static_ready(static_ready),
    .scan_id(scan_id), .grant_id(grant_id), .busy(busy)
  );

  typedef struct { int r; bit w; bit rd; logic [19:0] addr; logic [31:0] wdata;
                   logic [31:0] rdata; int delay; bit ew; logic [31:0] erdata; } vec_t;
  typedef struct { int gid; bit w; bit r; logic [19:0] addr; logic [31:0] wdata; } gexp_t;
  typedef struct { logic [3:0] rdy; logic [31:0] rdata; bit err; } cexp_t;

  gexp_t gq[$];
  cexp_t cq[$];
  vec_t vecs[4];
  int pass_cnt = 0, total = 0, scan_cnt = 0, rcnt = 0, resp_delay = 1;
  bit scan_prev = 0, resp_en = 1, hold = 0;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic set_req(int r, bit w, bit rd, logic [19:0] a, logic [31:0] d);
    req_wen[r] = w;
    req_ren[r] = rd;
    req_addr[r*20 +: 20] = a;
    req_wdata[r*32 +: 32] = d;
  endtask

  task automatic tick();
    gexp_t g;
    cexp_t c;
    @(negedge clk);
    if (scan_id && !scan_prev) begin
      if (gq.size() == 0) chk("unexpected_grant", 64'(grant_id), 64'hFF);
      else begin
        g = gq.pop_front();
        chk("grant_id", 64'(grant_id), 64'(g.gid));
        chk("static_cmd", {static_wen, static_ren}, {g.w, g.r});
        chk("static_addr", 64'(static_addr), 64'(g.addr));
        if (g.w) chk("static_wdata", 64'(static_wdata), 64'(g.wdata));
      end
    end
    if (scan_id) scan_cnt++;
    scan_prev = scan_id;
    if (req_ready != 0) begin
      if (cq.size() == 0) chk("unexpected_ready", 64'(req_ready), 64'h0);
      else begin
        c = cq.pop_front();
        chk("req_ready", 64'(req_ready), 64'(c.rdy));
        chk("req_rdata", 64'(req_rdata), 64'(c.rdata));
        chk("req_err", 64'(req_err), 64'(c.err));
      end
      if (!hold) begin
        req_wen = req_wen & ~req_ready;
        req_ren = req_ren & ~req_ready;
      end else if (cq.size() == 0) begin
        req_wen = 0;
        req_ren = 0;
      end
    end
    if (resp_en && scan_id) begin
      rcnt++;
      resp_rdy = (rcnt == resp_delay);
    end else begin
      rcnt = 0;
      resp_rdy = 0;
    end
  endtask

  task automatic run_until_idle(string n);
    int b = 0;
    tick();
    while (((req_wen | req_ren) != 0 || busy) && b < 300) begin
      tick();
      b++;
    end
    if (b >= 300) chk({n, "_timeout"}, 64'(b), 64'h0);
  endtask

  task automatic push(int r, bit w, bit rd, logic [19:0] a, logic [31:0] d, logic [31:0] erd, bit err);
    gq.push_back('{gid: r, w: w, r: rd && !w, addr: a, wdata: d});
    cq.push_back('{rdy: 4'(1 << r), rdata: erd, err: err});
  endtask

  task automatic run_vec(vec_t v);
    set_req(v.r, v.w, v.rd, v.addr, v.wdata);
    static_rdata = v.rdata;
    resp_delay = v.delay;
    scan_cnt = 0;
    push(v.r, v.w, v.rd, v.addr, v.wdata, v.erdata, 0);
    run_until_idle("vec");
    chk("scan_cycles", 64'(scan_cnt), 64'(v.delay));
  endtask

  initial begin
    vecs[0] = '{r: 2, w: 0, rd: 1, addr: 20'h00104, wdata: 0, rdata: 32'h1234_5678, delay: 4, ew: 0, erdata: 32'h1234_5678};
    vecs[1] = '{r: 1, w: 1, rd: 1, addr: 20'h0ABCD, wdata: 32'hA5A5_0001, rdata: 32'hFFFF_0000, delay: 2, ew: 1, erdata: 32'h0};
    vecs[2] = '{r: 0, w: 1, rd: 0, addr: 20'hFFFFF, wdata: 32'hFFFF_FFFF, rdata: 32'h5555_5555, delay: 1, ew: 1, erdata: 32'h0};
    vecs[3] = '{r: 3, w: 0, rd: 1, addr: 20'h00000, wdata: 0, rdata: 32'h0BAD_F00D, delay: 3, ew: 0, erdata: 32'h0BAD_F00D};
    tick();
    tick();
    chk("rst_outputs", {req_ready, req_rdata, req_err, static_wen, static_ren, static_addr,
                        static_wdata, scan_id, grant_id, busy}, '0);
    rst = 0;
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);
    // all of 0,1,3 held from a fresh pointer: rotation must go 0,1,3,0
    rst = 1;
    tick();
    rst = 0;
    hold = 1;
    static_rdata = 32'h1111_0000;
    resp_delay = 1;
    for (int r = 0; r < 4; r++) if (r != 2) set_req(r, 0, 1, 20'(r * 'h100), 0);
    push(0, 0, 1, 20'h000, 0, 32'h1111_0000, 0);
    push(1, 0, 1, 20'h100, 0, 32'h1111_0000, 0);
    push(3, 0, 1, 20'h300, 0, 32'h1111_0000, 0);
    push(0, 0, 1, 20'h000, 0, 32'h1111_0000, 0);
    run_until_idle("rotate");
    hold = 0;
    chk("rotate_drained", 64'(gq.size() + cq.size()), 64'h0);
    // abort mid-BUSY, then pointer must be back at 0
    run_vec(vecs[0]);
    resp_en = 0;
    set_req(3, 0, 1, 20'h33333, 0);
    gq.push_back('{gid: 3, w: 0, r: 1, addr: 20'h33333, wdata: 0});
    for (int b = 0; b < 10 && !scan_id; b++) tick();
    chk("abort_busy", 64'(scan_id), 64'h1);
    tick();
    rst = 1;
    req_ren = 0;
    tick();
    chk("abort_outputs", {req_ready, static_wen, static_ren, static_addr, static_wdata,
                          scan_id, busy, grant_id}, '0);
    rst = 0;
    resp_en = 1;
    resp_delay = 2;
    static_rdata = 32'h2222_3333;
    set_req(1, 0, 1, 20'h00011, 0);
    set_req(3, 0, 1, 20'h00033, 0);
    push(1, 0, 1, 20'h00011, 0, 32'h2222_3333, 0);
    push(3, 0, 1, 20'h00033, 0, 32'h2222_3333, 0);
    run_until_idle("post_abort");
    chk("post_abort_drained", 64'(gq.size() + cq.size()), 64'h0);
    // stray static_ready while idle
    idle_pulse = 1;
    tick();
    idle_pulse = 0;
    tick();
    chk("idle_ready_busy", 64'(busy), 64'h0);
    chk("idle_ready_req", 64'(req_ready), 64'h0);
`ifdef GROUP_ARB_TIMEOUT_EN
    resp_en = 0;
    scan_cnt = 0;
    set_req(0, 0, 1, 20'h00ABC, 0);
    push(0, 0, 1, 20'h00ABC, 0, 32'hDEAD_BEEF, 1);
    run_until_idle("wdog");
    chk("wdog_cycles", 64'(scan_cnt), 64'd16);
    resp_en = 1;
    resp_delay = 16;
    scan_cnt = 0;
    static_rdata = 32'h7777_8888;
    set_req(2, 0, 1, 20'h00DEF, 0);
    push(2, 0, 1, 20'h00DEF, 0, 32'h7777_8888, 0);
    run_until_idle("wdog_race");
    chk("wdog_race_cycles", 64'(scan_cnt), 64'd16);
`endif
    chk("final_drained", 64'(gq.size() + cq.size()), 64'h0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
